// File: rtl/div_iter_unit_pkg.sv
// Shared constants and state encoding for the iterative EX-stage divider.
package div_iter_unit_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so WIDTH+1 bits hold the
    // shifted value and the top bit of the difference is the borrow.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_q     = ~w_diff[WIDTH];
    assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) feeding the HI/LO write path.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_cancel,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;
    logic [WIDTH-1:0] w_q_raw;
    logic             w_start;
    logic             w_load;

    assign w_a_neg = div_signed & dividend[WIDTH-1];
    assign w_b_neg = div_signed & divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor  : divisor;

    // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    assign w_q_raw = {r_dvd[WIDTH-2:0], w_step_q};
    assign w_start = (r_state == DIV_IDLE) && (w_next_state == DIV_CALC);
    assign w_load  = (w_next_state == DIV_DONE);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_IDLE: if (div_start) w_next_state = DIV_CALC;
            DIV_CALC: if (r_cnt == LAST_CNT) w_next_state = DIV_DONE;
            DIV_DONE: w_next_state = DIV_IDLE;
            default:  w_next_state = DIV_IDLE;
        endcase
        if (div_cancel) w_next_state = DIV_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= DIV_IDLE;
        else         r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quo   <= '0;
            r_rmd   <= '0;
        end else begin
            r_busy <= (w_next_state == DIV_CALC);
            r_done <= w_load;
            if (w_start) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_dvd   <= w_a_mag;
                r_dvs   <= w_b_mag;
                // Divide by zero must yield all ones for DIV too, so no quotient negate then.
                r_q_neg <= (w_a_neg ^ w_b_neg) & (w_b_mag != '0);
                r_r_neg <= w_a_neg;
            end else if (r_state == DIV_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_rem <= w_step_rem;
                r_dvd <= w_q_raw;
            end
            if (w_load) begin
                r_quo <= r_q_neg ? -w_q_raw    : w_q_raw;
                r_rmd <= r_r_neg ? -w_step_rem : w_step_rem;
            end
        end
    end

    assign div_busy  = r_busy;
    assign div_done  = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rmd;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed vectors, monitor checks results and done timing.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_cancel;
    logic        div_busy;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    exp_t sb_q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    div_iter_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_cancel (div_cancel),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (resetn && div_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_quotient"},   quotient,    e.q);
                check({e.name, "_remainder"},  remainder,   e.r);
                check({e.name, "_done_cycle"}, 32'(cyc),    32'(e.cyc));
            end
        end
    end

    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] qe, input logic [31:0] re,
                         input string nm);
        exp_t e;
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        if (push) begin
            e.q    = qe;
            e.r    = re;
            e.cyc  = cyc + DIV_LATENCY;
            e.name = nm;
            sb_q.push_back(e);
        end
        @(negedge clk);
        div_start = 1'b0;
    endtask

    // Issues one operation and walks its whole latency checking busy; spur_k>1 pulses
    // a junk start at that cycle offset, which the DUT must ignore.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] qe, input logic [31:0] re,
                          input string nm, input int spur_k);
        issue(sgn, a, b, 1'b1, qe, re, nm);
        for (int k = 1; k <= DIV_LATENCY; k++) begin
            if (k > 1) @(negedge clk);
            div_start = (k == spur_k);
            if (k == spur_k) begin
                div_signed = 1'b1;
                dividend   = 32'hDEAD_BEEF;
                divisor    = 32'h0000_0003;
            end
            check($sformatf("%s_busy_c%0d", nm, k), 32'(div_busy), 32'(k < DIV_LATENCY));
        end
        div_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_cancel = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_done", 32'(div_done), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_quotient",  quotient,  32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy_after", 32'(div_busy), 32'd0);

        run_op(1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         "divu_100_7",   0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2",     0);
        run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, "div_7_m2",     0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, "div_ovf",      0);
        run_op(1'b0, 32'h1234_5678, 32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678, "divu_by0",     5);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0000,  32'hFFFF_FFFF, 32'hFFFF_FFF9, "div_by0_neg",  0);
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'h0000_000E, 32'hFFFF_FFFE, "div_m100_m7",  0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001,  32'hFFFF_FFFF, 32'h0000_0000, "divu_max_1",   0);
        run_op(1'b0, 32'h0000_0005, 32'h0000_0009,  32'h0000_0000, 32'h0000_0005, "divu_5_9",     0);
        run_op(1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         "divu_prior",   0);

        // Cancel at cycle 10 of DIVU 50/5; restart at cycle 12 completes at cycle 45.
        issue(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, "");
        repeat (9) @(negedge clk);
        div_cancel = 1'b1;
        @(negedge clk);
        div_cancel = 1'b0;
        check("cancel_busy",      32'(div_busy), 32'd0);
        check("cancel_done",      32'(div_done), 32'd0);
        check("cancel_quotient",  quotient,      32'd14);
        check("cancel_remainder", remainder,     32'd2);
        run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "divu_restart", 0);

        // Cancel in the final CALC cycle must suppress both the done pulse and the load.
        issue(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, "");
        repeat (31) @(negedge clk);
        div_cancel = 1'b1;
        @(negedge clk);
        div_cancel = 1'b0;
        check("late_cancel_busy",      32'(div_busy), 32'd0);
        check("late_cancel_done",      32'(div_done), 32'd0);
        check("late_cancel_quotient",  quotient,      32'd10);
        check("late_cancel_remainder", remainder,     32'd0);
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation clears everything at once.
        issue(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, "");
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_busy",      32'(div_busy), 32'd0);
        check("midrst_done",      32'(div_done), 32'd0);
        check("midrst_quotient",  quotient,      32'd0);
        check("midrst_remainder", remainder,     32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_idle_busy", 32'(div_busy), 32'd0);

        // Start and cancel together in IDLE: nothing starts.
        @(negedge clk);
        div_start  = 1'b1;
        div_cancel = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd9;
        divisor    = 32'd3;
        @(negedge clk);
        div_start  = 1'b0;
        div_cancel = 1'b0;
        check("start_cancel_busy", 32'(div_busy), 32'd0);
        repeat (36) @(negedge clk);
        check("start_cancel_quotient", quotient, 32'd0);

        check("pending_results", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
